ppu_system: RTL and testbench

//  Top-level of the PPU board build for Nexys3 (100 MHz).
//  - Generates 640x480@60 VGA sync timing from a /4 pixel-clock enable.
//  - Drives a 1 Hz-class heartbeat LED derived from the frame counter.
//  - Is the root of the board design; the pixel-data path attaches later to the

---
 rtl/ppu_pkg.sv | 37 +++
 rtl/vga_timing.sv | 87 ++++++++
 rtl/ppu_system.sv | 83 ++++++++
 tb/tb_ppu_system.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ppu_pkg.sv
`default_nettype none
// ============================================================================
// ppu_pkg : VGA 640x480@60 timing defaults and counter-width helpers
// Revision: 1.0
// ============================================================================
package ppu_pkg;

    localparam int DEF_CLK_FREQ     = 100_000_000;
    localparam int DEF_PIX_DIV      = 4;
    localparam int DEF_H_ACTIVE     = 640;
    localparam int DEF_H_FP         = 16;
    localparam int DEF_H_SYNC       = 96;
    localparam int DEF_H_BP         = 48;
    localparam int DEF_V_ACTIVE     = 480;
    localparam int DEF_V_FP         = 10;
    localparam int DEF_V_SYNC       = 2;
    localparam int DEF_V_BP         = 33;
    localparam int DEF_BLINK_FRAMES = 30;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // A counter over a range of one still needs a single bit to exist.
    function automatic int cnt_width(input int total);
        return (total > 1) ? $clog2(total) : 1;
    endfunction

    localparam int DEF_HCNT_W = cnt_width(DEF_H_TOTAL);
    localparam int DEF_VCNT_W = cnt_width(DEF_V_TOTAL);

    typedef struct packed {
        logic hsync;
        logic vsync;
    } sync_t;

endpackage
`default_nettype wire

// File: rtl/vga_timing.sv
`default_nettype none
// ============================================================================
// vga_timing : pixel enable, h/v counters, registered active-low syncs
// Revision: 1.0
// ============================================================================
module vga_timing
    import ppu_pkg::*;
#(
    parameter int PIX_DIV  = DEF_PIX_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HCNT_W   = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int VCNT_W   = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input  logic              clk,
    input  logic              rst_i,
    output logic              hsync_o,
    output logic              vsync_o,
    output logic [HCNT_W-1:0] hcount_o,
    output logic [VCNT_W-1:0] vcount_o,
    output logic              active_o,
    output logic              eof_o
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int DIV_W    = cnt_width(PIX_DIV);

    logic [DIV_W-1:0]  div_q, div_d;
    logic [HCNT_W-1:0] hcount_q, hcount_d;
    logic [VCNT_W-1:0] vcount_q, vcount_d;
    sync_t             sync_q, sync_d;
    logic              tick, h_last, v_last;

    always_comb begin
        tick     = (div_q == DIV_W'(PIX_DIV - 1));
        h_last   = (hcount_q == HCNT_W'(H_TOTAL - 1));
        v_last   = (vcount_q == VCNT_W'(V_TOTAL - 1));
        div_d    = tick ? '0 : div_q + 1'b1;
        hcount_d = hcount_q;
        vcount_d = vcount_q;
        if (tick) begin
            if (h_last) begin
                hcount_d = '0;
                vcount_d = v_last ? '0 : vcount_q + 1'b1;
            end else begin
                hcount_d = hcount_q + 1'b1;
            end
        end
        // Decoded from the current counters so the pins lag them by one clk.
        sync_d.hsync = !((hcount_q >= HCNT_W'(HS_START)) && (hcount_q < HCNT_W'(HS_END)));
        sync_d.vsync = !((vcount_q >= VCNT_W'(VS_START)) && (vcount_q < VCNT_W'(VS_END)));
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            div_q    <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            sync_q   <= '{hsync: 1'b1, vsync: 1'b1};
        end else begin
            div_q    <= div_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            sync_q   <= sync_d;
        end
    end

    assign hsync_o  = sync_q.hsync;
    assign vsync_o  = sync_q.vsync;
    assign hcount_o = hcount_q;
    assign vcount_o = vcount_q;
    assign active_o = (hcount_q < HCNT_W'(H_ACTIVE)) && (vcount_q < VCNT_W'(V_ACTIVE));
    assign eof_o    = tick && h_last && v_last;

endmodule
`default_nettype wire

// File: rtl/ppu_system.sv
`default_nettype none
// ============================================================================
// ppu_system : Nexys3 board top - VGA sync timing plus frame-based heartbeat LED
// Revision: 1.0
// ============================================================================
module ppu_system
    import ppu_pkg::*;
#(
    parameter int CLK_FREQ     = DEF_CLK_FREQ,
    parameter int PIX_DIV      = DEF_PIX_DIV,
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic clk,
    input  logic btns,
    output logic Led,
    output logic Hsync,
    output logic Vsync
);

    localparam int HCNT_W  = cnt_width(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam int VCNT_W  = cnt_width(V_ACTIVE + V_FP + V_SYNC + V_BP);
    localparam int FRAME_W = cnt_width(BLINK_FRAMES);

    logic [HCNT_W-1:0]  hcount;
    logic [VCNT_W-1:0]  vcount;
    logic               active;
    logic               eof;
    logic [FRAME_W-1:0] frame_q;
    logic               led_q;
    logic               pixel_path_unused;

    vga_timing #(
        .PIX_DIV  (PIX_DIV),
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .HCNT_W   (HCNT_W),
        .VCNT_W   (VCNT_W)
    ) u_vga_timing (
        .clk      (clk),
        .rst_i    (btns),
        .hsync_o  (Hsync),
        .vsync_o  (Vsync),
        .hcount_o (hcount),
        .vcount_o (vcount),
        .active_o (active),
        .eof_o    (eof)
    );

    always_ff @(posedge clk) begin
        if (btns) begin
            frame_q <= '0;
            led_q   <= 1'b0;
        end else if (eof) begin
            if (frame_q == FRAME_W'(BLINK_FRAMES - 1)) begin
                frame_q <= '0;
                led_q   <= ~led_q;
            end else begin
                frame_q <= frame_q + 1'b1;
            end
        end
    end

    assign Led = led_q;

    // Counters and active flag are reserved for the pixel-data path.
    assign pixel_path_unused = ^{hcount, vcount, active, (CLK_FREQ > 0)};

endmodule
`default_nettype wire

// File: tb/tb_ppu_system.sv
`default_nettype none
// Bench for ppu_system: one default-timing instance and two shrunken-timing
// instances checked against constant vectors and an arithmetic timing model.
module tb_ppu_system;

    logic       clk = 1'b0;
    logic [2:0] btns;
    logic [2:0] hs, vs, led;

    always #5 clk = ~clk;

    ppu_system u_def (
        .clk(clk), .btns(btns[0]), .Led(led[0]), .Hsync(hs[0]), .Vsync(vs[0])
    );

    ppu_system #(
        .PIX_DIV(2), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .BLINK_FRAMES(1)
    ) u_r1 (
        .clk(clk), .btns(btns[1]), .Led(led[1]), .Hsync(hs[1]), .Vsync(vs[1])
    );

    ppu_system #(
        .PIX_DIV(1), .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .BLINK_FRAMES(3)
    ) u_r3 (
        .clk(clk), .btns(btns[2]), .Led(led[2]), .Hsync(hs[2]), .Vsync(vs[2])
    );

    typedef struct {
        int pd; int ha; int hf; int hsw; int hb;
        int va; int vf; int vsw; int vb; int bf;
    } cfg_t;

    typedef struct {
        int   dut;
        int   edge_n;
        int   sig;      // 0 Hsync, 1 Vsync, 2 Led
        logic exp;
    } vec_t;

    cfg_t       cfg [3];
    int         n [3];          // edges since last reset edge, per instance
    int         mm [3];
    int         first_mm [3];
    int         falls [3];
    logic [2:0] hs_prev;
    bit         vs0_low, led0_high;
    int         n_pass = 0;
    int         n_total = 0;
    vec_t       vecs[$];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) n[i] <= btns[i] ? 0 : n[i] + 1;
    end

    // Expected {Hsync, Vsync, Led} after `cnt` edges since reset release.
    function automatic logic [2:0] model(input int i, input int cnt);
        cfg_t c      = cfg[i];
        int   ht     = c.ha + c.hf + c.hsw + c.hb;
        int   vt     = c.va + c.vf + c.vsw + c.vb;
        int   m      = (cnt > 0) ? cnt - 1 : 0;
        int   pix    = m / c.pd;
        int   h      = pix % ht;
        int   v      = (pix / ht) % vt;
        int   frames = cnt / (c.pd * ht * vt);
        logic hsy    = !(h >= c.ha + c.hf && h < c.ha + c.hf + c.hsw);
        logic vsy    = !(v >= c.va + c.vf && v < c.va + c.vf + c.vsw);
        logic ld     = ((frames / c.bf) % 2) == 1;
        return {hsy, vsy, ld};
    endfunction

    function automatic logic get_sig(input int i, input int sig);
        return (sig == 0) ? hs[i] : (sig == 1) ? vs[i] : led[i];
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        logic [2:0] e;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (hs_prev[i] === 1'b1 && hs[i] === 1'b0) falls[i]++;
            e = model(i, n[i]);
            if ({hs[i], vs[i], led[i]} !== e) begin
                if (mm[i] == 0) first_mm[i] = n[i];
                mm[i]++;
            end
        end
        hs_prev = hs;
        if (vs[0] !== 1'b1) vs0_low = 1'b1;
        if (led[0] !== 1'b0) led0_high = 1'b1;
    endtask

    task automatic report_trace(input string tag);
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("trace_%s_dut%0d(first_bad_edge=%0d)", tag, i, first_mm[i]), mm[i], 0);
            mm[i]       = 0;
            first_mm[i] = -1;
        end
    endtask

    initial begin
        int guard;
        int edges;

        cfg[0] = '{4, 640, 16, 96, 48, 480, 10, 2, 33, 30};
        cfg[1] = '{2, 8, 1, 2, 1, 4, 1, 1, 1, 1};
        cfg[2] = '{1, 8, 1, 2, 1, 4, 1, 2, 1, 3};

        // Edges counted from the first edge with btns=0; all instances released together.
        vecs.push_back('{0,    1, 0, 1'b1});
        vecs.push_back('{1,   19, 0, 1'b0});
        vecs.push_back('{1,   23, 0, 1'b1});
        vecs.push_back('{2,   60, 1, 1'b1});
        vecs.push_back('{2,   61, 1, 1'b0});
        vecs.push_back('{2,   84, 1, 1'b0});
        vecs.push_back('{2,   85, 1, 1'b1});
        vecs.push_back('{1,  120, 1, 1'b1});
        vecs.push_back('{1,  121, 1, 1'b0});
        vecs.push_back('{1,  144, 1, 1'b0});
        vecs.push_back('{1,  145, 1, 1'b1});
        vecs.push_back('{1,  167, 2, 1'b0});
        vecs.push_back('{1,  168, 2, 1'b1});
        vecs.push_back('{2,  287, 2, 1'b0});
        vecs.push_back('{2,  288, 2, 1'b1});
        vecs.push_back('{1,  335, 2, 1'b1});
        vecs.push_back('{1,  336, 2, 1'b0});
        vecs.push_back('{0, 2624, 0, 1'b1});
        vecs.push_back('{0, 2625, 0, 1'b0});
        vecs.push_back('{0, 3008, 0, 1'b0});
        vecs.push_back('{0, 3009, 0, 1'b1});
        vecs.push_back('{0, 5824, 0, 1'b1});
        vecs.push_back('{0, 5825, 0, 1'b0});

        btns = 3'b111;
        repeat (8) step();
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("reset_hsync_dut%0d", i), hs[i], 1);
            cmp($sformatf("reset_vsync_dut%0d", i), vs[i], 1);
            cmp($sformatf("reset_led_dut%0d", i), led[i], 0);
            mm[i] = 0; first_mm[i] = -1; falls[i] = 0;
        end
        hs_prev   = hs;
        vs0_low   = 1'b0;
        led0_high = 1'b0;
        btns      = 3'b000;

        foreach (vecs[k]) begin
            while (n[vecs[k].dut] < vecs[k].edge_n) step();
            cmp($sformatf("vec%0d_dut%0d_edge%0d_sig%0d", k, vecs[k].dut, vecs[k].edge_n, vecs[k].sig),
                get_sig(vecs[k].dut, vecs[k].sig), vecs[k].exp);
        end

        while (n[0] < 50000) step();
        cmp("run50k_hsync_pulses", falls[0], 15);
        cmp("run50k_vsync_went_low", vs0_low, 0);
        cmp("run50k_led_went_high", led0_high, 0);
        report_trace("run50k");

        guard = 0;
        while (hs[0] !== 1'b0 && guard < 5000) begin
            step();
            guard++;
        end
        cmp("hsync_low_before_midreset", hs[0], 0);
        repeat (50) step();
        btns[0] = 1'b1;
        step();
        cmp("midreset_hsync", hs[0], 1);
        cmp("midreset_vsync", vs[0], 1);
        cmp("midreset_led", led[0], 0);
        btns[0] = 1'b0;
        edges = 0;
        do begin
            step();
            edges++;
        end while (hs[0] !== 1'b0 && edges < 5000);
        cmp("midreset_next_hsync_fall_edge", edges, 2625);
        report_trace("midreset");

        for (int seg = 0; seg < 20; seg++) begin
            int rst_at [3];
            int rst_len [3];
            for (int i = 0; i < 3; i++) begin
                rst_at[i]  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 399)) : -100;
                rst_len[i] = $urandom_range(1, 3);
            end
            for (int c = 0; c < 400; c++) begin
                for (int i = 0; i < 3; i++)
                    btns[i] = (c >= rst_at[i] && c < rst_at[i] + rst_len[i]);
                step();
            end
            report_trace($sformatf("rand%0d", seg));
        end
        btns = 3'b000;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
